// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - copies the BIOS ROM image into instruction RAM while holding the CPU, then releases it.
module boot_loader #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ROM_ADDR_WIDTH = 8,
    parameter int                    RAM_ADDR_WIDTH = 10,
    parameter int unsigned           RAM_BASE       = 0,
    parameter logic [DATA_WIDTH-1:0] END_MARKER     = '1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reboot,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]     rom_q,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_data,
    output logic                      ram_we,
    output logic                      cpu_stall,
    output logic                      cpu_reset,
    output logic                      boot_done,
    output logic [ROM_ADDR_WIDTH:0]   words_copied,
    output logic [DATA_WIDTH-1:0]     checksum
);

    typedef enum logic [1:0] {HOLD, COPY, RELEASE, RUN} state_t;

    localparam logic [ROM_ADDR_WIDTH-1:0] LAST_IDX = '1;
    localparam logic [ROM_ADDR_WIDTH-1:0] IDX_ONE  = ROM_ADDR_WIDTH'(1);
    localparam logic [ROM_ADDR_WIDTH:0]   CNT_ONE  = (ROM_ADDR_WIDTH+1)'(1);

    state_t                    state;
    state_t                    state_nxt;
    logic [ROM_ADDR_WIDTH-1:0] idx;
    logic                      is_marker;

    always_comb begin
        state_nxt = state;
        rom_addr  = '0;
        ram_addr  = '0;
        ram_data  = '0;
        ram_we    = 1'b0;
        cpu_stall = 1'b1;
        cpu_reset = 1'b1;
        boot_done = 1'b0;
        is_marker = (rom_q == END_MARKER);
        case (state)
            HOLD: state_nxt = COPY;
            COPY: begin
                rom_addr = idx;
                if (!is_marker) begin
                    ram_we   = 1'b1;
                    ram_addr = RAM_ADDR_WIDTH'(RAM_BASE) + RAM_ADDR_WIDTH'(idx);
                    ram_data = rom_q;
                    if (idx == LAST_IDX) begin
                        state_nxt = RELEASE;
                    end
                end else begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                cpu_reset = 1'b0;
                state_nxt = RUN;
            end
            RUN: begin
                cpu_stall = 1'b0;
                cpu_reset = 1'b0;
                boot_done = 1'b1;
                if (reboot) begin
                    state_nxt = HOLD;
                end
            end
            default: state_nxt = HOLD;
        endcase
    end

    // Counters are cleared on the edge into HOLD as well, so a reboot reads zero in HOLD just like reset does.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HOLD;
            idx          <= '0;
            words_copied <= '0;
            checksum     <= '0;
        end else begin
            state <= state_nxt;
            if (state == HOLD || state_nxt == HOLD) begin
                idx          <= '0;
                words_copied <= '0;
                checksum     <= '0;
            end else if (ram_we) begin
                if (idx != LAST_IDX) begin
                    idx <= idx + IDX_ONE;
                end
                words_copied <= words_copied + CNT_ONE;
                checksum     <= checksum + rom_q;
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader against a ROM-walk reference model.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        reboot;

    logic [7:0]  rom_addr1, rom_addr2;
    logic [31:0] rom_q1, rom_q2;
    logic [9:0]  ram_addr1, ram_addr2;
    logic [31:0] ram_data1, ram_data2;
    logic        ram_we1, ram_we2;
    logic        cpu_stall1, cpu_stall2;
    logic        cpu_reset1, cpu_reset2;
    logic        boot_done1, boot_done2;
    logic [8:0]  words_copied1, words_copied2;
    logic [31:0] checksum1, checksum2;

    logic [31:0] rom1 [256];
    logic [31:0] rom2 [256];
    logic [41:0] wq1 [$];
    logic [41:0] wq2 [$];
    logic [41:0] exp_q [$];

    int checks   = 0;
    int failures = 0;
    int mon_err  = 0;

    always #5 clk = ~clk;

    assign rom_q1 = rom1[rom_addr1];
    assign rom_q2 = rom2[rom_addr2];

    boot_loader dut1 (
        .clk(clk), .reset(reset), .reboot(reboot),
        .rom_addr(rom_addr1), .rom_q(rom_q1),
        .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_we(ram_we1),
        .cpu_stall(cpu_stall1), .cpu_reset(cpu_reset1), .boot_done(boot_done1),
        .words_copied(words_copied1), .checksum(checksum1)
    );

    boot_loader #(.RAM_BASE(1020)) dut2 (
        .clk(clk), .reset(reset), .reboot(reboot),
        .rom_addr(rom_addr2), .rom_q(rom_q2),
        .ram_addr(ram_addr2), .ram_data(ram_data2), .ram_we(ram_we2),
        .cpu_stall(cpu_stall2), .cpu_reset(cpu_reset2), .boot_done(boot_done2),
        .words_copied(words_copied2), .checksum(checksum2)
    );

    // Records every RAM write and flags writes outside the stalled/reset window or non-zero buses after release.
    always @(negedge clk) begin
        if (ram_we1) wq1.push_back({ram_addr1, ram_data1});
        if (ram_we2) wq2.push_back({ram_addr2, ram_data2});
        if (ram_we1 && !(cpu_stall1 && cpu_reset1)) mon_err++;
        if (ram_we2 && !(cpu_stall2 && cpu_reset2)) mon_err++;
        if (!cpu_reset1 && (ram_we1 || rom_addr1 != 0 || ram_addr1 != 0 || ram_data1 != 0)) mon_err++;
        if (!cpu_reset2 && (ram_we2 || rom_addr2 != 0 || ram_addr2 != 0 || ram_data2 != 0)) mon_err++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Walks the ROM image: each word up to the first marker (or the end) is one write and one COPY cycle;
    // hitting the marker costs one more COPY cycle.
    function automatic void model(input logic [31:0] src[256], input int base,
                                  output int n, output int copy_cyc, output logic [31:0] cs);
        exp_q.delete();
        n = 0;
        copy_cyc = 0;
        cs = 0;
        for (int i = 0; i < 256; i++) begin
            copy_cyc++;
            if (src[i] == 32'hFFFF_FFFF) break;
            exp_q.push_back({10'((base + i) % 1024), src[i]});
            n++;
            cs = cs + src[i];
        end
    endfunction

    function automatic int q_diff(input logic [41:0] a[$], input logic [41:0] b[$]);
        int d = 0;
        for (int i = 0; i < a.size() && i < b.size(); i++) begin
            if (a[i] !== b[i]) d++;
        end
        return d;
    endfunction

    // Caller has just released reset (or taken the reboot edge) at a negedge with wq1 cleared.
    task automatic run_check(input string tag);
        int n, copy_cyc, cycles;
        logic [31:0] cs;
        model(rom1, 0, n, copy_cyc, cs);
        cycles = 0;
        while (!boot_done1 && cycles < 2000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        check($sformatf("%s_latency", tag), 64'(cycles), 64'(copy_cyc + 2));
        check($sformatf("%s_words", tag), 64'(words_copied1), 64'(n));
        check($sformatf("%s_checksum", tag), 64'(checksum1), 64'(cs));
        check($sformatf("%s_nwrites", tag), 64'(wq1.size()), 64'(exp_q.size()));
        check($sformatf("%s_writes", tag), 64'(q_diff(wq1, exp_q)), 64'd0);
        check($sformatf("%s_stall", tag), 64'(cpu_stall1), 64'd0);
        check($sformatf("%s_monitor", tag), 64'(mon_err), 64'd0);
    endtask

    task automatic reset_boot(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wq1.delete();
        run_check(tag);
    endtask

    task automatic fill_random(input int marker_pos);
        logic [31:0] d;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            if (d == 32'hFFFF_FFFF) d = 32'h0;
            rom1[i] = (i == marker_pos) ? 32'hFFFF_FFFF : d;
        end
    endtask

    initial begin
        int n2, cyc2, t;
        logic [31:0] cs2, saved_cs;

        reset  = 1'b1;
        reboot = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom1[i] = 32'(i + 1);
            rom2[i] = (i < 8) ? 32'(100 + i) : ((i == 8) ? 32'hFFFF_FFFF : 32'(i));
        end
        repeat (3) @(negedge clk);

        check("rst_stall", 64'(cpu_stall1), 64'd1);
        check("rst_cpu_reset", 64'(cpu_reset1), 64'd1);
        check("rst_we", 64'(ram_we1), 64'd0);
        check("rst_done", 64'(boot_done1), 64'd0);
        check("rst_words", 64'(words_copied1), 64'd0);
        check("rst_checksum", 64'(checksum1), 64'd0);

        reset = 1'b0;
        wq1.delete();
        wq2.delete();
        run_check("full");
        check("full_checksum_const", 64'(checksum1), 64'd32896);
        check("full_words_const", 64'(words_copied1), 64'd256);

        model(rom2, 1020, n2, cyc2, cs2);
        check("wrap_words", 64'(words_copied2), 64'd8);
        check("wrap_checksum", 64'(checksum2), 64'(cs2));
        check("wrap_nwrites", 64'(wq2.size()), 64'd8);
        check("wrap_writes", 64'(q_diff(wq2, exp_q)), 64'd0);
        check("wrap_addr4", 64'(wq2[4][41:32]), 64'd0);
        check("wrap_done", 64'(boot_done2), 64'd1);

        fill_random(3);
        rom1[0] = 32'd5;
        rom1[1] = 32'd6;
        rom1[2] = 32'd7;
        reset_boot("marker3");
        check("marker3_checksum_const", 64'(checksum1), 64'd18);
        check("marker3_words_const", 64'(words_copied1), 64'd3);

        fill_random(0);
        reset_boot("marker0");

        for (int k = 0; k < 4; k++) begin
            fill_random(int'($urandom_range(0, 400)));
            reset_boot($sformatf("rand%0d", k));
        end

        fill_random(999);
        reset_boot("pre_reboot");
        saved_cs = checksum1;
        @(negedge clk);
        reboot = 1'b1;
        wq1.delete();
        @(negedge clk);
        reboot = 1'b0;
        check("reboot_done_drop", 64'(boot_done1), 64'd0);
        check("reboot_hold_words", 64'(words_copied1), 64'd0);
        run_check("reboot");
        check("reboot_same_checksum", 64'(checksum1), 64'(saved_cs));

        fill_random(999);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        t = 0;
        while (!(cpu_reset1 && rom_addr1 == 8'd50) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("wait_idx50", 64'(t < 1000), 64'd1);
        reboot = 1'b1;
        @(negedge clk);
        reboot = 1'b0;
        check("midcopy_reboot_addr", 64'(rom_addr1), 64'd51);
        check("midcopy_reboot_stall", 64'(cpu_reset1), 64'd1);
        t = 0;
        while (rom_addr1 != 8'd100 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("wait_idx100", 64'(t < 1000), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_rom_addr", 64'(rom_addr1), 64'd0);
        check("midreset_words", 64'(words_copied1), 64'd0);
        check("midreset_checksum", 64'(checksum1), 64'd0);
        check("midreset_we", 64'(ram_we1), 64'd0);
        check("midreset_cpu_reset", 64'(cpu_reset1), 64'd1);
        reset = 1'b0;
        wq1.delete();
        run_check("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the ROM/RAM word width.
REQ-002 The block SHALL have parameter ROM_ADDR_WIDTH, default 8, meaning the BIOS ROM depth, 2^ROM_ADDR_WIDTH words.
REQ-003 The block SHALL have parameter RAM_ADDR_WIDTH, default 10, meaning the instruction RAM address width.
REQ-004 The block SHALL have parameter RAM_BASE, default 0, meaning the RAM address that receives ROM word 0.
REQ-005 The block SHALL have parameter END_MARKER, default all-ones, meaning the ROM word that terminates the copy early.
REQ-006 clk  in  1  single system clock; all state changes occur on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 reboot  in  1  request to re-run the boot copy; sampled every cycle.
REQ-009 rom_addr  out  ROM_ADDR_WIDTH  BIOS ROM read address.
REQ-010 rom_q  in  DATA_WIDTH  BIOS ROM data; combinational read, valid in the same cycle as rom_addr.
REQ-011 ram_addr  out  RAM_ADDR_WIDTH  instruction RAM write address.
REQ-012 ram_data  out  DATA_WIDTH  instruction RAM write data.
REQ-013 ram_we  out  1  instruction RAM write enable.
REQ-014 cpu_stall  out  1  holds the processor while high.
REQ-015 cpu_reset  out  1  processor reset pulse.
REQ-016 boot_done  out  1  high while the processor runs from the loaded image.
REQ-017 words_copied  out  ROM_ADDR_WIDTH+1  count of words written in the last or current boot.
REQ-018 checksum  out  DATA_WIDTH  sum of written words, modulo 2^DATA_WIDTH.

Function
REQ-019 The FSM SHALL have four states: HOLD, COPY, RELEASE and RUN.
REQ-020 HOLD: cpu_stall=1, cpu_reset=1, ram_we=0, rom_addr=0; the index, words_copied and checksum are cleared; the FSM goes to COPY on the next edge unconditionally.
REQ-021 COPY, word not the marker: with index i, rom_addr=i; if rom_q != END_MARKER, then ram_we=1, ram_addr=RAM_BASE+i (truncated to RAM_ADDR_WIDTH) and ram_data=rom_q, all combinationally in the same cycle.
REQ-022 COPY, word written: on each written word, the index, words_copied and checksum (checksum += rom_q, wrap-around) SHALL update at the edge.
REQ-023 COPY, end marker: if rom_q == END_MARKER, then ram_we=0, no counters change, and the next state is RELEASE.
REQ-024 COPY, last address: if i == 2^ROM_ADDR_WIDTH-1 and the word is written, the next state is RELEASE; the index SHALL NOT wrap to 0 and re-copy.
REQ-025 COPY outputs: cpu_stall=1, cpu_reset=1 throughout COPY.
REQ-026 RELEASE: lasts exactly one cycle with cpu_stall=1, cpu_reset=0, ram_we=0; the next state is RUN.
REQ-027 RUN: cpu_stall=0, cpu_reset=0, boot_done=1, ram_we=0; words_copied and checksum hold their values.
REQ-028 reboot in RUN: the next state is HOLD, and boot_done drops on that edge.
REQ-029 reboot in HOLD, COPY or RELEASE: ignored; the copy is never restarted mid-transfer.
REQ-030 Latency: total boot time from leaving reset to boot_done=1 SHALL be 1 (HOLD) + N (COPY) + 1 (RELEASE) cycles.
- N = number of words written, or words written + 1 when the marker is hit.
REQ-031 ram_we SHALL never be high outside COPY.
REQ-032 ram_addr, ram_data and rom_addr SHALL be 0 when ram_we=0 outside COPY.

Reset
REQ-033 reset=1 at any edge, including mid-COPY, SHALL force HOLD and clear the index, words_copied and checksum.
REQ-034 While in HOLD after reset: cpu_stall=1, cpu_reset=1, ram_we=0, boot_done=0.
REQ-035 Copying SHALL begin on the first edge with reset=0.
REQ-036 A reset during COPY SHALL restart the copy from ROM word 0.

Verification
REQ-037 Full ROM (default parameters), words k = k+1, no marker -> 256 writes, RAM[k]=k+1, words_copied=256, checksum=32896, boot_done at cycle 258 after reset release.
REQ-038 ROM word 3 = FFFFFFFF, words 0..2 = 5,6,7 -> exactly 3 writes, words_copied=3, checksum=18, boot_done 5 cycles after HOLD exits.
REQ-039 Marker at word 0 -> no writes, words_copied=0, checksum=0, RELEASE follows the first COPY cycle.
REQ-040 RAM_BASE=1020, RAM_ADDR_WIDTH=10, 8 words then marker -> words 4..7 written to addresses 0..3 (address wrap).
REQ-041 reset asserted at COPY index 100 -> HOLD, counters 0, copy restarts at rom_addr=0; reboot pulsed at index 50 -> no effect.
REQ-042 reboot pulsed for 1 cycle in RUN -> boot_done=0 next cycle, full re-copy, identical checksum.
